// File: rtl/usb_rx_ctrl_if.sv
// RX buffer write port of the USB full-speed receive controller.
// The controller (master) flushes and fills the buffer and reads back its fill level.
interface usb_rx_ctrl_if;
   logic       flush;
   logic       store_rx_packet_data;
   logic [7:0] rx_packet_data;
   logic [6:0] buffer_occupancy;

   modport master (
      output flush,
      output store_rx_packet_data,
      output rx_packet_data,
      input  buffer_occupancy
   );

   modport slave (
      input  flush,
      input  store_rx_packet_data,
      input  rx_packet_data,
      output buffer_occupancy
   );
endinterface

// File: rtl/usb_rx_ctrl.sv
// Packet-level sequencer for the USB full-speed receive path: SYNC/PID/token/payload checks.
// Optional macro USB_RX_HANDSHAKE_EXT_EN also accepts NAK and STALL handshakes.
module usb_rx_ctrl #(
   parameter logic [6:0] DEV_ADDR  = 7'h79,
   parameter logic [3:0] DEV_ENDP  = 4'h0,
   parameter int         MAX_PKT   = 64,
   parameter int         BUF_DEPTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               byte_done,
   input  logic [7:0]         rx_byte,
   input  logic               eop_detected,
   input  logic               bits_pending,
   input  logic               crc5_ok,
   input  logic               crc16_ok,
   output logic               crc_clear,
   output logic [3:0]         rx_packet,
   output logic               rx_data_ready,
   output logic               rx_transfer_active,
   output logic               rx_error,
   usb_rx_ctrl_if.master      buf_if
);

   localparam int         PW        = $clog2(MAX_PKT + 1);
   localparam logic [7:0] SYNC_BYTE = 8'h80;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
`ifdef USB_RX_HANDSHAKE_EXT_EN
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PID,
      TOK1,
      TOK2,
      DATA,
      WAIT_EOP,
      ERR_WAIT
   } state_t;

   typedef struct packed {
      state_t        state;
      logic [3:0]    pid;
      logic [6:0]    addr;
      logic [3:0]    endp;
      logic [7:0]    h0;
      logic [7:0]    h1;
      logic [1:0]    hcnt;
      logic [PW-1:0] pay;
      logic [3:0]    rx_packet;
      logic          rx_data_ready;
      logic          rx_transfer_active;
      logic          rx_error;
      logic          flush;
      logic          store;
      logic [7:0]    store_data;
   } regs_t;

   regs_t r;
   regs_t n;
   logic  pid_ok;
   logic  is_token;
   logic  tok_match;
   logic  crc_clear_c;

   // NOTE: state is held only in always_ff with non-blocking (<=) assignments;
   // always_comb uses blocking (=) so the later EOP phase sees the byte phase's result.
   always_ff @(posedge clk) begin
      // NOTE: the two-byte delay line is an ordinary register, so it is cleared with
      // everything else; no stale payload byte can leak into the next packet.
      if (rst) r <= '0;
      else     r <= n;
   end

   // A byte and an EOP in the same cycle are handled in that order: the byte phase
   // updates n, then the EOP phase decides from n.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      n                 = r;
      n.rx_data_ready   = 1'b0;
      n.flush           = 1'b0;
      n.store           = 1'b0;
      crc_clear_c       = 1'b0;
      pid_ok            = (rx_byte[7:4] == ~rx_byte[3:0]);
      is_token          = 1'b0;
      tok_match         = 1'b0;

      if (byte_done) begin
         case (r.state)
            IDLE: begin
               if (rx_byte == SYNC_BYTE) begin
                  n.state              = PID;
                  n.rx_transfer_active = 1'b1;
                  n.rx_error           = 1'b0;
                  n.rx_packet          = '0;
               end else begin
                  n.state    = ERR_WAIT;
                  n.rx_error = 1'b1;
               end
            end
            PID: begin
               n.pid = rx_byte[3:0];
               if (!pid_ok) begin
                  n.state    = ERR_WAIT;
                  n.rx_error = 1'b1;
               end else begin
                  case (rx_byte[3:0])
                     PID_OUT, PID_IN: begin
                        n.state     = TOK1;
                        crc_clear_c = 1'b1;
                     end
                     PID_DATA0, PID_DATA1: begin
                        n.state     = DATA;
                        n.flush     = 1'b1;
                        n.hcnt      = '0;
                        n.pay       = '0;
                        crc_clear_c = 1'b1;
                     end
`ifdef USB_RX_HANDSHAKE_EXT_EN
                     PID_ACK, PID_NAK, PID_STALL: begin
`else
                     PID_ACK: begin
`endif
                        n.state     = WAIT_EOP;
                        crc_clear_c = 1'b1;
                     end
                     default: begin
                        n.state    = ERR_WAIT;
                        n.rx_error = 1'b1;
                     end
                  endcase
               end
            end
            TOK1: begin
               n.addr  = rx_byte[6:0];
               n.endp  = {r.endp[3:1], rx_byte[7]};
               n.state = TOK2;
            end
            TOK2: begin
               n.endp  = {rx_byte[2:0], r.endp[0]};
               n.state = WAIT_EOP;
            end
            DATA: begin
               // The last two bytes held here are the CRC16 once EOP arrives.
               n.h0 = rx_byte;
               n.h1 = r.h0;
               if (r.hcnt == 2'd2) begin
                  if (r.pay == PW'(MAX_PKT) ||
                      buf_if.buffer_occupancy == 7'(BUF_DEPTH)) begin
                     n.state    = ERR_WAIT;
                     n.rx_error = 1'b1;
                  end else begin
                     n.store      = 1'b1;
                     n.store_data = r.h1;
                     n.pay        = r.pay + 1'b1;
                  end
               end else begin
                  n.hcnt = r.hcnt + 2'd1;
               end
            end
            WAIT_EOP: begin
               n.state    = ERR_WAIT;
               n.rx_error = 1'b1;
            end
            default: ;
         endcase
      end

      if (eop_detected) begin
         case (n.state)
            PID, TOK1, TOK2: begin
               n.state              = IDLE;
               n.rx_error           = 1'b1;
               n.rx_transfer_active = 1'b0;
            end
            WAIT_EOP: begin
               is_token  = (n.pid == PID_IN) || (n.pid == PID_OUT);
               tok_match = (n.addr == DEV_ADDR) && (n.endp == DEV_ENDP) && crc5_ok;
               if (!bits_pending && (!is_token || tok_match)) n.rx_packet = n.pid;
               else                                           n.rx_error  = 1'b1;
               n.state              = IDLE;
               n.rx_transfer_active = 1'b0;
            end
            DATA: begin
               if (n.hcnt == 2'd2 && !bits_pending && crc16_ok) begin
                  n.rx_packet     = n.pid;
                  n.rx_data_ready = 1'b1;
               end else begin
                  n.rx_error = 1'b1;
               end
               n.state              = IDLE;
               n.rx_transfer_active = 1'b0;
            end
            ERR_WAIT: begin
               n.state              = IDLE;
               n.rx_transfer_active = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign crc_clear                   = crc_clear_c & ~rst;
   assign rx_packet                   = r.rx_packet;
   assign rx_data_ready               = r.rx_data_ready;
   assign rx_transfer_active          = r.rx_transfer_active;
   assign rx_error                    = r.rx_error;
   assign buf_if.flush                = r.flush;
   assign buf_if.store_rx_packet_data = r.store;
   assign buf_if.rx_packet_data       = r.store_data;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed self-checking bench for usb_rx_ctrl: handshake, token, data, overflow,
// premature EOP, bad SYNC and mid-packet reset.
module tb_usb_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic       eop_detected;
   logic       bits_pending;
   logic       crc5_ok;
   logic       crc16_ok;
   logic       crc_clear;
   logic [3:0] rx_packet;
   logic       rx_data_ready;
   logic       rx_transfer_active;
   logic       rx_error;

   usb_rx_ctrl_if bus ();

   usb_rx_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .byte_done          (byte_done),
      .rx_byte            (rx_byte),
      .eop_detected       (eop_detected),
      .bits_pending       (bits_pending),
      .crc5_ok            (crc5_ok),
      .crc16_ok           (crc16_ok),
      .crc_clear          (crc_clear),
      .rx_packet          (rx_packet),
      .rx_data_ready      (rx_data_ready),
      .rx_transfer_active (rx_transfer_active),
      .rx_error           (rx_error),
      .buf_if             (bus)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_flush = 0;
   int         n_store = 0;
   int         n_ready = 0;
   int         n_active = 0;
   logic [7:0] st_data [0:127];
   logic       cc_seen;

   // Pulse counters sample just after each rising edge, clear of the negedge stimulus.
   always begin
      @(posedge clk);
      #1;
      if (bus.flush) n_flush++;
      if (bus.store_rx_packet_data) begin
         if (n_store < 128) st_data[n_store] = bus.rx_packet_data;
         n_store++;
      end
      if (rx_data_ready)      n_ready++;
      if (rx_transfer_active) n_active++;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All stimulus tasks start and end on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      byte_done = 1'b1;
      rx_byte   = b;
      #1;
      cc_seen   = crc_clear;
      @(negedge clk);
      byte_done = 1'b0;
   endtask

   task automatic send_eop(input logic bp, input logic c5, input logic c16);
      eop_detected = 1'b1;
      bits_pending = bp;
      crc5_ok      = c5;
      crc16_ok     = c16;
      @(negedge clk);
      eop_detected = 1'b0;
      bits_pending = 1'b0;
      crc5_ok      = 1'b0;
      crc16_ok     = 1'b0;
   endtask

   task automatic send_byte_eop(input logic [7:0] b, input logic c5);
      byte_done    = 1'b1;
      rx_byte      = b;
      eop_detected = 1'b1;
      crc5_ok      = c5;
      @(negedge clk);
      byte_done    = 1'b0;
      eop_detected = 1'b0;
      crc5_ok      = 1'b0;
   endtask

   task automatic clear_counts();
      n_flush  = 0;
      n_store  = 0;
      n_ready  = 0;
      n_active = 0;
   endtask

   initial begin
      rst                  = 1'b1;
      byte_done            = 1'b0;
      rx_byte              = 8'h00;
      eop_detected         = 1'b0;
      bits_pending         = 1'b0;
      crc5_ok              = 1'b0;
      crc16_ok             = 1'b0;
      bus.buffer_occupancy = 7'd0;
      repeat (3) @(negedge clk);

      check("rst_packet", 32'(rx_packet), 0);
      check("rst_active", 32'(rx_transfer_active), 0);
      check("rst_error", 32'(rx_error), 0);
      check("rst_ready", 32'(rx_data_ready), 0);
      check("rst_flush", 32'(bus.flush), 0);
      check("rst_store", 32'(bus.store_rx_packet_data), 0);
      check("rst_data", 32'(bus.rx_packet_data), 0);
      check("rst_crc_clear", 32'(crc_clear), 0);
      rst = 1'b0;
      @(negedge clk);

      // ACK handshake: active exactly from SYNC through EOP
      clear_counts();
      send_byte(8'h80);
      check("ack_sync_cc", 32'(cc_seen), 0);
      check("ack_active", 32'(rx_transfer_active), 1);
      send_byte(8'hD2);
      check("ack_crc_clear", 32'(cc_seen), 1);
      send_eop(1'b0, 1'b0, 1'b0);
      check("ack_packet", 32'(rx_packet), 32'h2);
      check("ack_error", 32'(rx_error), 0);
      check("ack_active_drop", 32'(rx_transfer_active), 0);
      check("ack_active_cycles", 32'(n_active), 2);

      // IN token to our address/endpoint; second byte carries CRC5 bits above endp
      send_byte(8'h80);
      send_byte(8'h69);
      send_byte(8'h79);
      send_byte(8'hA8);
      send_eop(1'b0, 1'b1, 1'b0);
      check("in_packet", 32'(rx_packet), 32'h9);
      check("in_error", 32'(rx_error), 0);

      // IN token to a different address
      send_byte(8'h80);
      send_byte(8'h69);
      send_byte(8'h78);
      send_byte(8'hA8);
      send_eop(1'b0, 1'b1, 1'b0);
      check("in_badaddr_error", 32'(rx_error), 1);
      check("in_badaddr_packet", 32'(rx_packet), 0);

      // OUT token whose last byte coincides with EOP
      send_byte(8'h80);
      check("sync_clears_error", 32'(rx_error), 0);
      send_byte(8'hE1);
      send_byte(8'h79);
      send_byte_eop(8'h00, 1'b1);
      check("out_same_cycle_packet", 32'(rx_packet), 32'h1);
      check("out_same_cycle_error", 32'(rx_error), 0);

      // DATA0 with three payload bytes plus two CRC bytes
      clear_counts();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_byte(8'h01);
      send_byte(8'hCA);
      send_byte(8'h70);
      send_byte(8'h12);
      send_byte(8'h34);
      send_eop(1'b0, 1'b0, 1'b1);
      check("d0_ready_now", 32'(rx_data_ready), 1);
      check("d0_active_now", 32'(rx_transfer_active), 0);
      @(negedge clk);
      check("d0_flush_count", 32'(n_flush), 1);
      check("d0_store_count", 32'(n_store), 3);
      check("d0_byte0", 32'(st_data[0]), 32'h01);
      check("d0_byte1", 32'(st_data[1]), 32'hCA);
      check("d0_byte2", 32'(st_data[2]), 32'h70);
      check("d0_ready_count", 32'(n_ready), 1);
      check("d0_packet", 32'(rx_packet), 32'h3);
      check("d0_error", 32'(rx_error), 0);

      // DATA1 with 66 payload bytes: 64 stored, error on the 65th store attempt
      clear_counts();
      send_byte(8'h80);
      send_byte(8'h4B);
      for (int k = 0; k < 68; k++) begin
         send_byte(8'(k));
         if (k == 65) check("ovf_before", 32'(rx_error), 0);
         if (k == 66) check("ovf_error", 32'(rx_error), 1);
      end
      check("ovf_active_hold", 32'(rx_transfer_active), 1);
      send_eop(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("ovf_store_count", 32'(n_store), 64);
      check("ovf_first", 32'(st_data[0]), 32'h00);
      check("ovf_last", 32'(st_data[63]), 32'h3F);
      check("ovf_no_ready", 32'(n_ready), 0);
      check("ovf_active_idle", 32'(rx_transfer_active), 0);
      check("ovf_packet", 32'(rx_packet), 0);

      // DATA1 into a full buffer: nothing stored
      clear_counts();
      bus.buffer_occupancy = 7'd64;
      send_byte(8'h80);
      send_byte(8'h4B);
      send_byte(8'h10);
      send_byte(8'h11);
      send_byte(8'h12);
      send_byte(8'h13);
      send_eop(1'b0, 1'b0, 1'b1);
      bus.buffer_occupancy = 7'd0;
      @(negedge clk);
      check("full_store_count", 32'(n_store), 0);
      check("full_error", 32'(rx_error), 1);
      check("full_active", 32'(rx_transfer_active), 0);

      // EOP with bits pending straight after the DATA0 PID
      clear_counts();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_eop(1'b1, 1'b0, 1'b1);
      check("early_eop_error", 32'(rx_error), 1);
      check("early_eop_active", 32'(rx_transfer_active), 0);
      check("early_eop_packet", 32'(rx_packet), 0);
      check("early_eop_ready", 32'(n_ready), 0);

      // Bad SYNC byte, then a good ACK clears the error
      send_byte(8'h81);
      check("bad_sync_error", 32'(rx_error), 1);
      check("bad_sync_active", 32'(rx_transfer_active), 0);
      send_eop(1'b0, 1'b0, 1'b0);
      send_byte(8'h80);
      send_byte(8'hD2);
      send_eop(1'b0, 1'b0, 1'b0);
      check("recover_error", 32'(rx_error), 0);
      check("recover_packet", 32'(rx_packet), 32'h2);

      // NAK handshake depends on the optional extension
      send_byte(8'h80);
      send_byte(8'h5A);
      send_eop(1'b0, 1'b0, 1'b0);
`ifdef USB_RX_HANDSHAKE_EXT_EN
      check("nak_packet", 32'(rx_packet), 32'hA);
      check("nak_error", 32'(rx_error), 0);
`else
      check("nak_packet", 32'(rx_packet), 0);
      check("nak_error", 32'(rx_error), 1);
`endif

      // Reset asserted together with the PID byte of an ACK
      send_byte(8'h80);
      send_byte(8'hD2);
      send_eop(1'b0, 1'b0, 1'b0);
      send_byte(8'h80);
      byte_done = 1'b1;
      rx_byte   = 8'hD2;
      rst       = 1'b1;
      #1;
      check("rst_mid_crc_clear", 32'(crc_clear), 0);
      @(negedge clk);
      byte_done = 1'b0;
      check("rst_mid_active", 32'(rx_transfer_active), 0);
      check("rst_mid_error", 32'(rx_error), 0);
      check("rst_mid_packet", 32'(rx_packet), 0);
      check("rst_mid_flush", 32'(bus.flush), 0);
      rst = 1'b0;
      @(negedge clk);
      send_byte(8'h80);
      send_byte(8'hD2);
      send_eop(1'b0, 1'b0, 1'b0);
      check("post_rst_packet", 32'(rx_packet), 32'h2);
      check("post_rst_error", 32'(rx_error), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
